// File: rtl/jellyvl_synctimer_timer.sv
// Local time counter with fractional rate and one-entry +/-1 adjust port.
// Time advances NUMERATOR/DENOMINATOR units per clk: the integer STEP is
// always added and a fractional accumulator contributes a carry when it
// overflows DENOMINATOR. An accepted adjust is held for one clk and then
// folded into the next increment. A set strobe loads an absolute time.
// Optional feature macro: JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN adds
// saturating counters of applied +1 / -1 adjusts.
module jellyvl_synctimer_timer #(
  parameter int TIMER_WIDTH = 64,
  parameter int NUMERATOR   = 10,
  parameter int DENOMINATOR = 3
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   adjust_sign,
  input  logic                   adjust_valid,
  output logic                   adjust_ready,
  output logic [TIMER_WIDTH-1:0] current_time
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
  ,
  output logic [15:0]            adj_count_plus,
  output logic [15:0]            adj_count_minus
`endif
);

  localparam int FRAC_W = $clog2(DENOMINATOR) + 1;
  localparam int STEP   = NUMERATOR / DENOMINATOR;
  localparam int REM    = NUMERATOR % DENOMINATOR;

  localparam logic [FRAC_W-1:0]      REM_F  = FRAC_W'(REM);
  localparam logic [FRAC_W-1:0]      DEN_F  = FRAC_W'(DENOMINATOR);
  localparam logic [TIMER_WIDTH-1:0] STEP_T = TIMER_WIDTH'(STEP);

  logic [TIMER_WIDTH-1:0] current_time_q, current_time_d;
  logic [FRAC_W-1:0]      frac_q, frac_d;
  logic                   pending_q, pending_d;
  logic                   pend_sign_q, pend_sign_d;
  logic                   adjust_ready_q, adjust_ready_d;

  logic                   accept;
  logic [FRAC_W-1:0]      frac_sum;
  logic                   carry;
  logic                   adj_up, adj_dn;

  // Next-state: fractional carry, pending-adjust application, set override.
  always_comb begin
    accept   = adjust_valid && adjust_ready_q;
    frac_sum = frac_q + REM_F;
    carry    = (frac_sum >= DEN_F);
    adj_up   = pending_q && !pend_sign_q;
    adj_dn   = pending_q &&  pend_sign_q;

    frac_d         = carry ? frac_sum - DEN_F : frac_sum;
    // Modular arithmetic at TIMER_WIDTH bits gives the natural wrap.
    current_time_d = current_time_q + STEP_T
                   + TIMER_WIDTH'(carry) + TIMER_WIDTH'(adj_up)
                   - TIMER_WIDTH'(adj_dn);
    pending_d      = accept;
    pend_sign_d    = accept ? adjust_sign : pend_sign_q;
    // Ready drops for the clk the accepted adjust sits in the pending slot.
    adjust_ready_d = !accept;

    // Set wins over increment and over any pending or coincident adjust.
    if (set_valid) begin
      current_time_d = set_time;
      frac_d         = '0;
      pending_d      = 1'b0;
      adjust_ready_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_time_q <= '0;
      frac_q         <= '0;
      pending_q      <= 1'b0;
      pend_sign_q    <= 1'b0;
      adjust_ready_q <= 1'b0;
    end else begin
      current_time_q <= current_time_d;
      frac_q         <= frac_d;
      pending_q      <= pending_d;
      pend_sign_q    <= pend_sign_d;
      adjust_ready_q <= adjust_ready_d;
    end
  end

  assign current_time = current_time_q;
  assign adjust_ready = adjust_ready_q;

`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
  logic [15:0] adj_count_plus_q, adj_count_plus_d;
  logic [15:0] adj_count_minus_q, adj_count_minus_d;

  // Count adjusts when they actually reach current_time; saturate, clear on set.
  always_comb begin
    adj_count_plus_d  = adj_count_plus_q;
    adj_count_minus_d = adj_count_minus_q;
    if (set_valid) begin
      adj_count_plus_d  = '0;
      adj_count_minus_d = '0;
    end else begin
      if (adj_up && adj_count_plus_q != 16'hFFFF)
        adj_count_plus_d = adj_count_plus_q + 16'd1;
      if (adj_dn && adj_count_minus_q != 16'hFFFF)
        adj_count_minus_d = adj_count_minus_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_count_plus_q  <= '0;
      adj_count_minus_q <= '0;
    end else begin
      adj_count_plus_q  <= adj_count_plus_d;
      adj_count_minus_q <= adj_count_minus_d;
    end
  end

  assign adj_count_plus  = adj_count_plus_q;
  assign adj_count_minus = adj_count_minus_q;
`endif

endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// Directed bench for jellyvl_synctimer_timer. Instance A runs at 10/3,
// instance B at 1/1 for the wrap case. Expectations are queued as each
// step is driven and popped/compared once the DUT has clocked.
module tb_jellyvl_synctimer_timer;

  localparam int TW = 64;

  typedef struct {
    string         tag;
    logic          sel_b;
    logic [TW-1:0] t;
    logic          rdy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] a_set_time = '0, b_set_time = '0;
  logic          a_set_valid = 1'b0, b_set_valid = 1'b0;
  logic          a_adj_sign = 1'b0, b_adj_sign = 1'b0;
  logic          a_adj_valid = 1'b0, b_adj_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [TW-1:0] a_time, b_time;
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
  logic [15:0]   a_cp, a_cm, b_cp, b_cm;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  jellyvl_synctimer_timer #(.TIMER_WIDTH(TW), .NUMERATOR(10), .DENOMINATOR(3)) u_a (
    .rst(rst), .clk(clk),
    .set_time(a_set_time), .set_valid(a_set_valid),
    .adjust_sign(a_adj_sign), .adjust_valid(a_adj_valid),
    .adjust_ready(a_ready), .current_time(a_time)
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
    , .adj_count_plus(a_cp), .adj_count_minus(a_cm)
`endif
  );

  jellyvl_synctimer_timer #(.TIMER_WIDTH(TW), .NUMERATOR(1), .DENOMINATOR(1)) u_b (
    .rst(rst), .clk(clk),
    .set_time(b_set_time), .set_valid(b_set_valid),
    .adjust_sign(b_adj_sign), .adjust_valid(b_adj_valid),
    .adjust_ready(b_ready), .current_time(b_time)
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
    , .adj_count_plus(b_cp), .adj_count_minus(b_cm)
`endif
  );

  task automatic expect_a(input string tag, input logic [TW-1:0] t, input logic rdy);
    exp_t e;
    e.tag = tag; e.sel_b = 1'b0; e.t = t; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic expect_b(input string tag, input logic [TW-1:0] t, input logic rdy);
    exp_t e;
    e.tag = tag; e.sel_b = 1'b1; e.t = t; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t          e;
    logic [TW-1:0] ot;
    logic          or_;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      ot  = e.sel_b ? b_time  : a_time;
      or_ = e.sel_b ? b_ready : a_ready;
      checks++;
      assert (ot === e.t) else begin
        errors++;
        $error("FAIL %s time: got %0d (0x%h) want %0d (0x%h)", e.tag, ot, ot, e.t, e.t);
      end
      checks++;
      assert (or_ === e.rdy) else begin
        errors++;
        $error("FAIL %s ready: got %b want %b", e.tag, or_, e.rdy);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
  task automatic check_cnt(input string tag, input logic [15:0] p, input logic [15:0] m);
    checks++;
    assert (a_cp === p && a_cm === m) else begin
      errors++;
      $error("FAIL %s counts: got +%0d -%0d want +%0d -%0d", tag, a_cp, a_cm, p, m);
    end
  endtask
`endif

  initial begin
    logic [TW-1:0] t;

    // Reset state
    #12;
    expect_a("reset_a", 64'd0, 1'b0);
    expect_b("reset_b", 64'd0, 1'b0);
    check_now();

    // T1: free run from reset release, 10/3 per clk
    @(posedge clk); #1;
    rst = 1'b0;
    expect_a("t1_e1", 64'd3, 1'b1);  expect_b("t1_b1", 64'd1, 1'b1); tick();
    expect_a("t1_e2", 64'd6, 1'b1);  tick();
    expect_a("t1_e3", 64'd10, 1'b1); tick();
    expect_a("t1_e4", 64'd13, 1'b1); tick();
    expect_a("t1_e5", 64'd16, 1'b1); tick();
    expect_a("t1_e6", 64'd20, 1'b1); expect_b("t1_b6", 64'd6, 1'b1); tick();

    // T2: one-clk set to 1000
    a_set_time = 64'd1000; a_set_valid = 1'b1;
    expect_a("t2_set", 64'd1000, 1'b1); tick();
    a_set_valid = 1'b0;
    expect_a("t2_run", 64'd1003, 1'b1); tick();

    // T3: single +1 adjust (frac=1 here); ready low one clk
    a_adj_valid = 1'b1; a_adj_sign = 1'b0;
    expect_a("t3_acc", 64'd1006, 1'b0); tick();
    a_adj_valid = 1'b0;
    expect_a("t3_apply", 64'd1011, 1'b1); tick();
    expect_a("t3_after", 64'd1014, 1'b1); tick();

    // T4: -1 adjust held for 10 clks from a fresh set (frac=0)
    a_set_valid = 1'b1;
    expect_a("t4_set", 64'd1000, 1'b1); tick();
    a_set_valid = 1'b0;
    a_adj_valid = 1'b1; a_adj_sign = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      t = 64'd1000 + 64'(3 * k) + 64'(k / 3) - 64'(k / 2);
      expect_a($sformatf("t4_k%0d", k), t, (k % 2) == 0);
      tick();
    end
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
    check_cnt("t4_cnt", 16'd0, 16'd5);
`endif
    a_adj_valid = 1'b0;
    expect_a("t4_idle", 64'd1031, 1'b1); tick();

    // T5: wrap at 1/1 and a -1 adjust holding time at 0
    b_set_time = 64'hFFFF_FFFF_FFFF_FFFE; b_set_valid = 1'b1;
    expect_b("t5_fffe", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1); tick();
    b_set_valid = 1'b0;
    expect_b("t5_ffff", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1); tick();
    b_adj_valid = 1'b1; b_adj_sign = 1'b1;
    expect_b("t5_zero", 64'd0, 1'b0); tick();
    b_adj_valid = 1'b0;
    expect_b("t5_hold", 64'd0, 1'b1); tick();
    expect_b("t5_one", 64'd1, 1'b1); tick();

    // T6: set coinciding with an adjust handshake discards the adjust
    a_set_time = 64'd5000; a_set_valid = 1'b1;
    a_adj_valid = 1'b1; a_adj_sign = 1'b0;
    expect_a("t6_set", 64'd5000, 1'b1); tick();
    a_set_valid = 1'b0; a_adj_valid = 1'b0;
    expect_a("t6_drop", 64'd5003, 1'b1); tick();
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
    check_cnt("t6_cnt", 16'd0, 16'd0);
`endif

    // T6: async reset while an adjust is pending
    a_adj_valid = 1'b1; a_adj_sign = 1'b0;
    expect_a("t6_pend", 64'd5006, 1'b0); tick();
    a_adj_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_a("t6_rst", 64'd0, 1'b0);
    check_now();
`ifdef JELLYVL_SYNCTIMER_TIMER_ADJ_COUNT_EN
    check_cnt("t6_rst_cnt", 16'd0, 16'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    expect_a("t6_rel1", 64'd3, 1'b1); tick();
    expect_a("t6_rel2", 64'd6, 1'b1); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
